// File: rtl/reduce_pkg.sv
// Shared types and constants for the sequential AND/OR/XOR (and optional popcount) reducer.
// The popcount path is enabled with the REDUCE_POPCOUNT_EN macro.
package reduce_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } state_e;

    // Accumulator seeds: identity elements of each reduction.
    localparam logic AccAndInit = 1'b1;
    localparam logic AccOrInit  = 1'b0;
    localparam logic AccXorInit = 1'b0;

    // Result registers come out of reset cleared.
    localparam logic ResInit = 1'b0;

    function automatic int unsigned pop_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/reduce_chunk.sv
// Combinational reduction of one CHUNK-bit slice into AND/OR/XOR bits and, with
// REDUCE_POPCOUNT_EN, the slice's bit count.
module reduce_chunk
    import reduce_pkg::*;
#(
    parameter int unsigned CHUNK = 4
) (
    input  logic [CHUNK-1:0]              chunk_i,
    output logic                          and_o,
    output logic                          or_o,
`ifdef REDUCE_POPCOUNT_EN
    output logic                          xor_o,
    output logic [pop_width(CHUNK)-1:0]   pop_o
`else
    output logic                          xor_o
`endif
);

    assign and_o = &chunk_i;
    assign or_o  = |chunk_i;
    assign xor_o = ^chunk_i;

`ifdef REDUCE_POPCOUNT_EN
    localparam int unsigned PopW = pop_width(CHUNK);

    always_comb begin
        pop_o = '0;
        for (int i = 0; i < CHUNK; i++) begin
            pop_o = pop_o + PopW'(chunk_i[i]);
        end
    end
`endif

endmodule

// File: rtl/reduce_seq.sv
// Sequential WIDTH-bit AND/OR/XOR reducer folding CHUNK bits per clock behind valid/ready
// handshakes. Define REDUCE_POPCOUNT_EN to add the out_popcnt result.
module reduce_seq
    import reduce_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WIDTH-1:0]              in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          out_and,
    output logic                          out_or,
`ifdef REDUCE_POPCOUNT_EN
    output logic                          out_xor,
    output logic [pop_width(WIDTH)-1:0]   out_popcnt
`else
    output logic                          out_xor
`endif
);

    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned CntW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             acc_and_q, acc_and_d, acc_or_q, acc_or_d, acc_xor_q, acc_xor_d;
    logic             res_and_q, res_and_d, res_or_q, res_or_d, res_xor_q, res_xor_d;
    logic             chunk_and, chunk_or, chunk_xor;
    logic             fold_and, fold_or, fold_xor;

`ifdef REDUCE_POPCOUNT_EN
    localparam int unsigned PopW  = pop_width(WIDTH);
    localparam int unsigned CPopW = pop_width(CHUNK);

    logic [PopW-1:0]  acc_pop_q, acc_pop_d, res_pop_q, res_pop_d, fold_pop;
    logic [CPopW-1:0] chunk_pop;
`endif

    reduce_chunk #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .chunk_i (shift_q[CHUNK-1:0]),
        .and_o   (chunk_and),
        .or_o    (chunk_or),
`ifdef REDUCE_POPCOUNT_EN
        .xor_o   (chunk_xor),
        .pop_o   (chunk_pop)
`else
        .xor_o   (chunk_xor)
`endif
    );

    assign fold_and = acc_and_q & chunk_and;
    assign fold_or  = acc_or_q | chunk_or;
    assign fold_xor = acc_xor_q ^ chunk_xor;
`ifdef REDUCE_POPCOUNT_EN
    assign fold_pop = acc_pop_q + PopW'(chunk_pop);
`endif

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        acc_and_d = acc_and_q;
        acc_or_d  = acc_or_q;
        acc_xor_d = acc_xor_q;
        res_and_d = res_and_q;
        res_or_d  = res_or_q;
        res_xor_d = res_xor_q;
`ifdef REDUCE_POPCOUNT_EN
        acc_pop_d = acc_pop_q;
        res_pop_d = res_pop_q;
`endif
        in_ready  = 1'b0;
        out_valid = 1'b0;

        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    shift_d   = in_data;
                    cnt_d     = '0;
                    acc_and_d = AccAndInit;
                    acc_or_d  = AccOrInit;
                    acc_xor_d = AccXorInit;
`ifdef REDUCE_POPCOUNT_EN
                    acc_pop_d = '0;
`endif
                    state_d   = StBusy;
                end
            end
            StBusy: begin
                shift_d   = shift_q >> CHUNK;
                acc_and_d = fold_and;
                acc_or_d  = fold_or;
                acc_xor_d = fold_xor;
`ifdef REDUCE_POPCOUNT_EN
                acc_pop_d = fold_pop;
`endif
                // Last slice: publish straight from the fold so DONE starts with the result.
                if (cnt_q == CntW'(NCHUNK - 1)) begin
                    cnt_d     = '0;
                    res_and_d = fold_and;
                    res_or_d  = fold_or;
                    res_xor_d = fold_xor;
`ifdef REDUCE_POPCOUNT_EN
                    res_pop_d = fold_pop;
`endif
                    state_d   = StDone;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StDone: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            shift_q   <= '0;
            cnt_q     <= '0;
            acc_and_q <= AccAndInit;
            acc_or_q  <= AccOrInit;
            acc_xor_q <= AccXorInit;
            res_and_q <= ResInit;
            res_or_q  <= ResInit;
            res_xor_q <= ResInit;
`ifdef REDUCE_POPCOUNT_EN
            acc_pop_q <= '0;
            res_pop_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            acc_and_q <= acc_and_d;
            acc_or_q  <= acc_or_d;
            acc_xor_q <= acc_xor_d;
            res_and_q <= res_and_d;
            res_or_q  <= res_or_d;
            res_xor_q <= res_xor_d;
`ifdef REDUCE_POPCOUNT_EN
            acc_pop_q <= acc_pop_d;
            res_pop_q <= res_pop_d;
`endif
        end
    end

    assign out_and = res_and_q;
    assign out_or  = res_or_q;
    assign out_xor = res_xor_q;
`ifdef REDUCE_POPCOUNT_EN
    assign out_popcnt = res_pop_q;
`endif

endmodule

// File: doc/reduce_seq.md
# reduce_seq

Parametrised, sequential successor to the team's fixed 4-bit AND/OR/XOR reduction gates. It reduces a WIDTH-bit operand to its AND, OR and XOR bits, folding CHUNK bits per clock. A valid/ready handshake on both sides lets it sit between a producer and a consumer in the datapath. Optionally it also produces a population count of the operand.

## Interface
Parameters:
- WIDTH, 16, operand width in bits; must be ≥1 and an integer multiple of CHUNK.
- CHUNK, 4, bits folded per cycle; 1 ≤ CHUNK ≤ WIDTH. Derived: NCHUNK = WIDTH/CHUNK.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  producer offers in_data.
- in_ready  out  1  block can accept; high only in IDLE.
- in_data  in  WIDTH  operand; sampled only on the accepting edge.
- out_valid  out  1  result registers hold a valid result.
- out_ready  in  1  consumer takes the result.
- out_and  out  1  AND of all WIDTH operand bits.
- out_or  out  1  OR of all WIDTH operand bits.
- out_xor  out  1  XOR of all WIDTH operand bits (odd parity).
- out_popcnt  out  $clog2(WIDTH+1)  number of set bits; present only with REDUCE_POPCOUNT_EN.

## Operation
FSM states: IDLE, BUSY, DONE.

IDLE:
- in_ready=1.
- On in_valid&&in_ready: load in_data into the shift register.
- Initialise accumulators: and=1, or=0, xor=0, pop=0, chunk counter=0.
- Go to BUSY.

BUSY:
- Each cycle, fold shift[CHUNK-1:0] into the accumulators: AND-reduce, OR-reduce, XOR-reduce, and add that chunk's bit count to pop.
- Shift the register right by CHUNK and increment the counter.
- After the fold with counter==NCHUNK-1, go to DONE.

DONE:
- out_valid=1. All outputs are held stable until out_valid&&out_ready, then go to IDLE.

Other rules:
- in_valid is ignored in BUSY and DONE; the producer must hold data until in_ready.
- Result outputs keep their last value in IDLE and BUSY; only out_valid qualifies them.
- The counter is $clog2(NCHUNK) bits (minimum 1) and never wraps past NCHUNK-1.
- Popcount arithmetic is unsigned. The adder is $clog2(WIDTH+1) bits wide and cannot overflow.

## Timing
Reset (async assert, sync deassert by the system):
- state=IDLE, in_ready=1, out_valid=0, out_and=0, out_or=0, out_xor=0, out_popcnt=0, counter=0.

Latency and throughput:
- Operand accepted at edge E → out_valid high after edge E+NCHUNK.
- With CHUNK=WIDTH, out_valid rises the edge after acceptance.
- Minimum initiation interval is NCHUNK+2 cycles: accept, NCHUNK folds, DONE, and at least one IDLE cycle.

Boundary conditions:
- Consumer handshake at edge D → in_ready=1 from D; the next accept is possible at edge D+1.
- out_ready high before out_valid has no effect.
- rst_n asserted in BUSY or DONE aborts the operation immediately. No result is emitted and the block is in IDLE on deassertion.

## Configuration
- REDUCE_POPCOUNT_EN defined:
  - out_popcnt port, pop accumulator and per-chunk adder are compiled in.
  - out_popcnt equals the count of ones in the accepted operand, valid with out_valid.
- REDUCE_POPCOUNT_EN undefined:
  - Port and logic are absent.
  - AND/OR/XOR behaviour and timing are identical.

## Structure
- Shared package reduce_pkg holds:
  - the state enumeration (IDLE=2'd0, BUSY=2'd1, DONE=2'd2);
  - accumulator reset constants;
  - the width helper for the popcount width.
- One sub-module, reduce_chunk: purely combinational, CHUNK bits in → chunk AND/OR/XOR and chunk popcount out.
- The top instantiates reduce_chunk once and contains the FSM, counter, shift register and accumulators.

## Test plan
All scenarios use WIDTH=16, CHUNK=4 unless stated.
1. Reset, then accept 16'h0000 → 4 edges later out_valid=1; and=0, or=0, xor=0, popcnt=0.
2. 16'hFFFF → and=1, or=1, xor=0, popcnt=16; 16'h0001 → and=0, or=1, xor=1, popcnt=1.
3. Sweep all 16 nibble values {4{n}} and a random set → compare against &, |, ^ and $countones references.
4. Backpressure with 16'h8421 and out_ready low for 6 cycles:
   - outputs stay and=0, or=1, xor=0, popcnt=4, and in_ready=0;
   - a second operand 16'h0007 held on in_valid is accepted only on the edge after the out handshake → xor=1, popcnt=3.
5. Assert rst_n low 2 cycles after accepting 16'hFFFF → out_valid never rises, in_ready=1 immediately, and a fresh operand after reset gives the correct result.
6. Parameter corners:
   - WIDTH=16, CHUNK=16 → out_valid on the edge after accept;
   - WIDTH=8, CHUNK=1 → 8-cycle latency, 8'h80 gives xor=1;
   - rebuild with REDUCE_POPCOUNT_EN undefined → port absent, other results unchanged.
